// File: rtl/thumb_uart_dump_pkg.sv
// thumb_uart_dump_pkg
// Shared definitions for the thumbnail UART dumper: thumbnail geometry,
// the two frame-header bytes and the sequencing state enumeration.
// No ports (package).
package thumb_uart_dump_pkg;

  localparam int THUMB_W = 40;
  localparam int THUMB_H = 30;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_CSUM
  } dump_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// Single-byte 8N1 UART transmitter, LSB first, idle high. Each bit is held
// CLK_DIV clock cycles, so one byte occupies exactly 10*CLK_DIV cycles.
// Ports:
//   clock   in   sole clock
//   resetn  in   asynchronous active-low reset (forces tx high at once)
//   data    in   [7:0] byte to send, captured when valid && ready
//   valid   in   request to send data
//   ready   out  transmitter can take a byte this cycle
//   tx      out  serial line
module uart_tx_byte #(
  parameter int CLK_DIV = 104
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  logic          active_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [8:0]    shift_q;
  logic          tx_q;
  logic          lastTick;

  assign lastTick = (baud_q == BAUD_LAST);

  // Ready is also raised in the final cycle of the stop bit so a waiting
  // byte starts right after the stop bit with no idle gap of our own.
  assign ready = !active_q || (lastTick && (bit_q == 4'd9));
  assign tx    = tx_q;

  // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit. shift_q holds the
  // remaining data bits with the stop bit's 1 shifted in behind them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else if (valid && ready) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= {1'b1, data};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (lastTick) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          bit_q    <= 4'd0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + BW'(1);
      end
    end
  end

endmodule

// File: rtl/thumb_uart_dump.sv
// thumb_uart_dump
// Streams one 40x30 thumbnail over UART on request: header A5 5A, the 1200
// pixels in row-major order read from an external synchronous buffer, then
// an 8-bit modulo-256 checksum of the pixels.
// Ports:
//   clock    in   sole clock (also clocks the buffer read port)
//   resetn   in   asynchronous active-low reset
//   start    in   one-cycle dump request, honoured only when idle
//   read_x   out  [5:0] buffer column 0..39
//   read_y   out  [4:0] buffer row 0..29
//   read_q   in   [7:0] buffer data, valid one clock after the address
//   uart_tx  out  serial output, 8N1, idle high
//   busy     out  dump in progress
//   done     out  one-cycle pulse when busy falls
module thumb_uart_dump
  import thumb_uart_dump_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  output logic [5:0] read_x,
  output logic [4:0] read_y,
  input  logic [7:0] read_q,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] X_LAST = 6'(THUMB_W - 1);
  localparam logic [4:0] Y_LAST = 5'(THUMB_H - 1);

  dump_state_e state_q;
  logic [5:0]  x_q;
  logic [4:0]  y_q;
  logic [7:0]  csum_q;
  logic        launch_q;
  logic        busy_q;
  logic        done_q;

  logic [5:0]  nextX_d;
  logic [4:0]  nextY_d;
  logic        lastPix;
  logic        txValid;
  logic        txReady;
  logic [7:0]  txData;

  assign read_x = x_q;
  assign read_y = y_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Row-major address step; x wraps into the next row, the final pixel
  // wraps back to (0,0) so the counters rest at zero when idle.
  always_comb begin
    nextX_d = x_q + 6'd1;
    nextY_d = y_q;
    if (x_q == X_LAST) begin
      nextX_d = '0;
      nextY_d = (y_q == Y_LAST) ? '0 : y_q + 5'd1;
    end
  end

  assign lastPix = (x_q == X_LAST) && (y_q == Y_LAST);

  // Byte offered to the transmitter. Pixels go straight from the buffer
  // during LATCH (the transmitter captures them), which keeps the pixel
  // overhead to the FETCH and LATCH cycles alone. Fixed bytes are offered
  // while launch_q is set, until the transmitter takes them.
  always_comb begin
    txValid = 1'b0;
    txData  = csum_q;
    unique case (state_q)
      ST_HDR0: begin
        txValid = launch_q;
        txData  = HDR0;
      end
      ST_HDR1: begin
        txValid = launch_q;
        txData  = HDR1;
      end
      ST_LATCH: begin
        txValid = 1'b1;
        txData  = read_q;
      end
      ST_CSUM: begin
        txValid = launch_q;
        txData  = csum_q;
      end
      default: begin
        txValid = 1'b0;
        txData  = csum_q;
      end
    endcase
  end

  // Sequencer. Once a byte has been handed over, txReady next rises in the
  // last stop-bit cycle, which is taken as "byte complete".
  // done_q blocks a start arriving in the done cycle itself.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      csum_q   <= '0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !done_q) begin
            state_q  <= ST_HDR0;
            launch_q <= 1'b1;
            busy_q   <= 1'b1;
            csum_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
          end
        end
        ST_HDR0: begin
          if (launch_q) begin
            if (txReady) launch_q <= 1'b0;
          end else if (txReady) begin
            state_q  <= ST_HDR1;
            launch_q <= 1'b1;
          end
        end
        ST_HDR1: begin
          if (launch_q) begin
            if (txReady) launch_q <= 1'b0;
          end else if (txReady) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          csum_q  <= csum_q + read_q;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (txReady) begin
            x_q <= nextX_d;
            y_q <= nextY_d;
            if (lastPix) begin
              state_q  <= ST_CSUM;
              launch_q <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_CSUM: begin
          if (launch_q) begin
            if (txReady) launch_q <= 1'b0;
          end else if (txReady) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clock (clock),
    .resetn(resetn),
    .data  (txData),
    .valid (txValid),
    .ready (txReady),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_thumb_uart_dump.sv
// tb_thumb_uart_dump
// Self-checking bench for thumb_uart_dump with CLK_DIV = 4. Expected bytes
// are computed from the buffer contents and pushed into a queue when a dump
// is requested; an independent UART decoder pops and compares each byte it
// receives off uart_tx.
module tb_thumb_uart_dump;

  localparam int CLK_DIV   = 4;
  localparam int BYTES     = 1203;
  localparam int BUSY_MAX  = 1203 * 40 + 2406 + 2;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [5:0] read_x;
  logic [4:0] read_y;
  logic [7:0] read_q;
  logic       uart_tx;
  logic       busy;
  logic       done;

  logic [7:0] mem [30][40];
  logic [7:0] expQ [$];

  int nChecks = 0;
  int nFails  = 0;
  int byteCount = 0;
  logic [7:0] lastByte = 8'h00;
  int busyCycles = 0;
  int doneCount = 0;
  int cornerCount = 0;
  int addrViol = 0;
  bit prevCorner = 0;
  bit corner;

  thumb_uart_dump #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .read_x (read_x),
    .read_y (read_y),
    .read_q (read_q),
    .uart_tx(uart_tx),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous thumbnail buffer: data one clock after the address.
  always @(posedge clock) begin
    if (read_x < 6'd40 && read_y < 5'd30) read_q <= mem[read_y][read_x];
    else read_q <= 8'h00;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Fill the buffer, queue the whole expected byte stream, pulse start and
  // check that the start bit appears one cycle after start is sampled.
  task automatic applyStimulus(input bit randomContent);
    int sum;
    sum = 0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        mem[y][x] = randomContent ? 8'($urandom) : 8'((y * 40 + x) % 256);
    expQ.push_back(8'hA5);
    expQ.push_back(8'h5A);
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) begin
        expQ.push_back(mem[y][x]);
        sum += int'(mem[y][x]);
      end
    expQ.push_back(8'(sum % 256));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("start_busy", int'(busy), 1);
    checkOutput("start_tx_still_idle", int'(uart_tx), 1);
    @(negedge clock);
    checkOutput("start_bit_latency", int'(uart_tx), 0);
  endtask

  task automatic waitBytes(input int target, input int maxCycles);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clock);
      if (byteCount >= target) begin
        ok = 1;
        break;
      end
    end
    checkOutput("bytes_reached", int'(ok), 1);
  endtask

  task automatic waitDone(input int maxCycles);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checkOutput("done_seen", int'(ok), 1);
  endtask

  // Address, busy and done bookkeeping sampled away from the active edge.
  always @(negedge clock) begin
    if (resetn) begin
      if (read_x > 6'd39 || read_y > 5'd29) addrViol++;
      if (!busy && (read_x != 6'd0 || read_y != 5'd0)) addrViol++;
      corner = (read_x == 6'd39) && (read_y == 5'd29);
      if (corner && !prevCorner) cornerCount++;
      prevCorner = corner;
      if (busy) busyCycles++;
      if (done) doneCount++;
    end
  end

  // UART decoder / scoreboard monitor. Samples once per cycle; each bit
  // must be constant for CLK_DIV samples. Bytes within a dump must be
  // separated by at most 2 idle-high cycles.
  logic [39:0] samp;
  logic [7:0]  rxByte;
  bit          aborted;
  bit          holdOk;
  bit          havePrev = 0;
  int          gapCnt = 0;

  always begin : uartDecoder
    @(negedge clock);
    if (!resetn) begin
      havePrev = 0;
      gapCnt   = 0;
    end else if (uart_tx === 1'b0) begin
      if (havePrev) checkOutput("byte_gap_le2", int'(gapCnt <= 2), 1);
      gapCnt  = 0;
      aborted = 0;
      samp    = '0;
      for (int j = 1; j < 40; j++) begin
        @(negedge clock);
        if (!resetn) begin
          aborted = 1;
          break;
        end
        samp[j] = uart_tx;
      end
      if (!aborted) begin
        holdOk = 1;
        for (int k = 0; k < 10; k++)
          for (int j = 1; j < CLK_DIV; j++)
            if (samp[k*CLK_DIV + j] !== samp[k*CLK_DIV]) holdOk = 0;
        checkOutput("bit_hold", int'(holdOk), 1);
        checkOutput("stop_bit", int'(samp[36]), 1);
        for (int b = 0; b < 8; b++) rxByte[b] = samp[(b + 1) * CLK_DIV];
        checkOutput("byte_expected", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) checkOutput("byte_value", int'(rxByte), int'(expQ.pop_front()));
        byteCount++;
        lastByte = rxByte;
        havePrev = 1;
      end else begin
        havePrev = 0;
      end
    end else if (busy) begin
      gapCnt++;
    end else begin
      havePrev = 0;
      gapCnt   = 0;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit quiet;
    int offset;
    resetn = 1'b0;
    start  = 1'b0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) mem[y][x] = 8'h00;

    // Reset held with start pulsed inside it.
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_uart_tx", int'(uart_tx), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_read_x", int'(read_x), 0);
    checkOutput("rst_read_y", int'(read_y), 0);
    resetn = 1'b1;
    quiet = 1;
    repeat (100) begin
      @(negedge clock);
      if (uart_tx !== 1'b1 || busy !== 1'b0) quiet = 0;
    end
    checkOutput("post_reset_quiet", int'(quiet), 1);

    // Random-content dump, reset during pixel byte 500.
    byteCount = 0;
    applyStimulus(1'b1);
    waitBytes(501, 501 * 50 + 100);
    for (int i = 0; i < 10 && uart_tx !== 1'b0; i++) @(negedge clock);
    offset = $urandom_range(1, 30);
    repeat (offset) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    checkOutput("midreset_tx_high", int'(uart_tx), 1);
    checkOutput("midreset_busy_low", int'(busy), 0);
    expQ.delete();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("post_midreset_idle", int'(busy), 0);

    // Full pattern dump with starts that must be ignored.
    byteCount   = 0;
    busyCycles  = 0;
    doneCount   = 0;
    cornerCount = 0;
    addrViol    = 0;
    applyStimulus(1'b0);
    waitBytes(10, 10 * 50 + 100);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone(BUSY_MAX + 200);
    start = 1'b1;
    @(negedge clock);
    checkOutput("dump_byte_count", byteCount, BYTES);
    checkOutput("dump_queue_drained", expQ.size(), 0);
    checkOutput("dump_checksum", int'(lastByte), 32'h28);
    checkOutput("dump_done_pulses", doneCount, 1);
    checkOutput("dump_corner_once", cornerCount, 1);
    checkOutput("dump_addr_bounds", addrViol, 0);
    checkOutput("dump_busy_max", int'(busyCycles <= BUSY_MAX), 1);
    checkOutput("dump_busy_min", int'(busyCycles >= BYTES * 10 * CLK_DIV), 1);
    checkOutput("done_cycle_start_ignored", int'(busy), 0);

    // Start one cycle after done: a second identical dump begins.
    byteCount = 0;
    applyStimulus(1'b0);
    waitBytes(30, 30 * 50 + 100);
    checkOutput("second_dump_addr_bounds", addrViol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/thumb_uart_dump.md
THUMB_UART_DUMP -- requirements
Module: thumb_uart_dump

Interface
REQ-001 Parameter CLK_DIV, default 104, clock cycles per UART bit (12 MHz / 115200 baud); legal range 4..4095.
REQ-002 clock  input  1  sole clock; also drives the thumbnail buffer read port.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to transmit one 40x30 thumbnail.
REQ-005 read_x  output  6  buffer column address, 0..39.
REQ-006 read_y  output  5  buffer row address, 0..29.
REQ-007 read_q  input  8  buffer data, valid exactly one clock after read_x/read_y are presented.
REQ-008 uart_tx  output  1  serial output: 8N1, LSB first, idle high.
REQ-009 busy  output  1  high from the cycle after start is accepted until the last stop bit completes.
REQ-010 done  output  1  one-cycle pulse in the cycle busy falls.

Function
REQ-011 Each dump SHALL transmit 1203 bytes in this order: 0xA5, 0x5A, 1200 pixel bytes, checksum.
REQ-012 Pixel bytes SHALL be in row-major order: y = 0..29 outer, x = 0..39 inner, each byte equal to read_q for that address.
REQ-013 The checksum SHALL be the 8-bit modulo-256 sum of the 1200 pixel bytes; the header is excluded.
REQ-014 States: IDLE, HDR0, HDR1, FETCH, LATCH, SEND, CSUM.
- IDLE -> HDR0 on start.
- HDR0 -> HDR1 and HDR1 -> FETCH, each after its byte completes.
- FETCH drives the address; LATCH captures read_q one cycle later and adds it to the checksum.
- SEND transmits the captured byte, then returns to FETCH, or goes to CSUM after x=39, y=29.
- CSUM -> IDLE after its byte completes.
REQ-015 Byte framing SHALL be 1 start bit (0), 8 data bits, 1 stop bit (1), each held exactly CLK_DIV cycles, so each byte takes 10*CLK_DIV cycles.
REQ-016 Consecutive bytes SHALL be separated by at most 2 cycles of idle-high, from the FETCH and LATCH overhead.
REQ-017 start SHALL be ignored while busy is high, including in the cycle done pulses.
REQ-018 start in the cycle after done SHALL be accepted.
REQ-019 The address counters SHALL wrap x from 39 to 0 and increment y, and SHALL never present x > 39 or y > 29.
REQ-020 read_x and read_y SHALL hold 0 in IDLE.
REQ-021 The baud counter SHALL be sized ceil(log2(CLK_DIV)) bits; the checksum accumulator SHALL be 8 bits and discard carries.
REQ-022 The first start bit SHALL begin on uart_tx 1 cycle after start is sampled.

Reset
REQ-023 While resetn is low, outputs SHALL be: uart_tx = 1, busy = 0, done = 0, read_x = 0, read_y = 0; state = IDLE; checksum = 0; bit and baud counters = 0.
REQ-024 Reset asserted mid-byte SHALL force uart_tx high immediately (asynchronously), with no partial stop bit.
REQ-025 After resetn rises, the block SHALL wait for a new start; no transfer resumes.
REQ-026 The checksum SHALL clear on every accepted start.

Structure
REQ-027 A shared package SHALL hold: THUMB_W = 40, THUMB_H = 30, HDR0 = 0xA5, HDR1 = 0x5A, and the state enumeration.
REQ-028 One sub-module, uart_tx_byte, SHALL be instantiated. Its interface: clock, resetn, CLK_DIV parameter, data[7:0], valid, ready, tx. It accepts a byte when valid and ready are both high.
REQ-029 The top level SHALL contain only the sequencing FSM, address counters and checksum.

Verification
REQ-030 Reset: hold resetn low for 5 cycles with start pulsed -> uart_tx = 1, busy = 0, no start bit within 100 cycles after release.
REQ-031 Full dump: CLK_DIV = 4, buffer model read_q = (y*40 + x) mod 256, pulse start once.
- Decoded stream = A5 5A 00 01 02 ... AF (1200 bytes), then checksum 0x28.
- done pulses once.
- busy is high for at most 1203*40 + 2406 + 2 cycles.
REQ-032 Bit timing: CLK_DIV = 4, first byte -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
REQ-033 Busy rejection: pulse start at byte 10 and in the done cycle -> exactly one 1203-byte dump.
- Then pulse start one cycle after done -> second identical dump.
REQ-034 Reset mid-operation: drop resetn during pixel byte 500 -> uart_tx high and busy low at once.
- A subsequent start yields a complete dump beginning with 0xA5 and checksum 0x28.
REQ-035 Address bounds: an assertion over the full dump -> read_x ≤ 39 and read_y ≤ 29 always; the (39,29) address is presented exactly once per dump.
